// File: rtl/alu_shift_seq.sv
// alu_shift_seq: steps an external combinational ALU one bit per cycle for shift/rotate ops.
// Latency: N+1 cycles from accept to done (N = effective count), 1 cycle when N = 0 or op unsupported.
// Backpressure: none; start is honoured only in IDLE, and a start while busy is dropped.
// Build option ALU_SEQ_COUNT_MASK_EN: when defined only count[4:0] is used (max 31 steps).
module alu_shift_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic        size,
  input  logic [15:0] operand,
  input  logic [7:0]  count,
  input  logic [5:0]  flags_in,
  output logic [4:0]  alu_op,
  output logic        alu_size,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cy,
  input  logic [15:0] alu_r,
  input  logic [5:0]  alu_flags,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [5:0]  flags
);

  localparam logic [4:0] ALUOP_ROL  = 5'd6;
  localparam logic [4:0] ALUOP_RORC = 5'd9;
  localparam logic [4:0] ALUOP_SHLA = 5'd13;
  localparam int         FLAG_CY    = 1;

  // Flags each op group may touch; AC (bit 0) is never written.
  localparam logic [5:0] MASK_ROT   = 6'b000110;
  localparam logic [5:0] MASK_SHIFT = 6'b111110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [4:0]  op_q;
  logic        size_q;
  logic [15:0] acc;
  logic [5:0]  flg;
  logic [7:0]  cnt;
  logic [15:0] result_q;
  logic [5:0]  flags_q;
  logic [7:0]  eff_count;
  logic        op_ok;
  logic        skip_run;
  logic [5:0]  upd_mask;
  logic [5:0]  flg_merged;

`ifdef ALU_SEQ_COUNT_MASK_EN
  assign eff_count = {3'b000, count[4:0]};
`else
  assign eff_count = count;
`endif

  assign op_ok    = (op >= ALUOP_ROL) && (op <= ALUOP_SHLA);
  assign skip_run = (eff_count == 8'd0) || !op_ok;

  // Rotates only carry CY/V; shifts also refresh the result-derived flags.
  assign upd_mask   = (op_q <= ALUOP_RORC) ? MASK_ROT : MASK_SHIFT;
  assign flg_merged = (flg & ~upd_mask) | (alu_flags & upd_mask);

  assign result = result_q;
  assign flags  = flags_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and ALU drive; ALU inputs are parked at zero outside RUN.
  always_comb begin
    state_nx = state;
    alu_op   = 5'd0;
    alu_size = 1'b0;
    alu_a    = 16'd0;
    alu_b    = 16'd0;
    alu_cy   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = skip_run ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        alu_op   = op_q;
        alu_size = size_q;
        alu_a    = acc;
        alu_b    = 16'd1;
        alu_cy   = flg[FLAG_CY];
        if (cnt == 8'd1) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Command latch, per-step accumulate, and result capture on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= 5'd0;
      size_q   <= 1'b0;
      acc      <= 16'd0;
      flg      <= 6'd0;
      cnt      <= 8'd0;
      result_q <= 16'd0;
      flags_q  <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            size_q <= size;
            acc    <= operand;
            flg    <= flags_in;
            cnt    <= eff_count;
            // Zero-count and unsupported ops complete with the operands untouched.
            if (skip_run) begin
              result_q <= operand;
              flags_q  <= flags_in;
            end
          end
        end
        S_RUN: begin
          acc <= alu_r;
          flg <= flg_merged;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            result_q <= alu_r;
            flags_q  <= flg_merged;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: directed checks of alu_shift_seq against a behavioural single-step ALU.
// Expected values are hand-computed; each scenario task compares inline.
module tb_alu_shift_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  op;
  logic        size;
  logic [15:0] operand;
  logic [7:0]  count;
  logic [5:0]  flags_in;
  logic [4:0]  alu_op;
  logic        alu_size;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cy;
  logic [15:0] alu_r;
  logic [5:0]  alu_flags;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [5:0]  flags;

  int total = 0;
  int bad   = 0;

  alu_shift_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .size(size),
    .operand(operand), .count(count), .flags_in(flags_in),
    .alu_op(alu_op), .alu_size(alu_size), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cy(alu_cy), .alu_r(alu_r), .alu_flags(alu_flags),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-bit ALU stand-in. Flags {Z,S,P,V,CY,AC}; AC is always 1 so leakage shows.
  always_comb begin
    logic [15:0] a;
    logic        co;
    logic        r_top;
    a     = alu_a;
    alu_r = a;
    co    = 1'b0;
    case (alu_op)
      5'd6:  begin co = alu_size ? a[15] : a[7];
               alu_r = alu_size ? {a[14:0], a[15]} : {a[15:8], a[6:0], a[7]}; end
      5'd7:  begin co = a[0];
               alu_r = alu_size ? {a[0], a[15:1]} : {a[15:8], a[0], a[7:1]}; end
      5'd8:  begin co = alu_size ? a[15] : a[7];
               alu_r = alu_size ? {a[14:0], alu_cy} : {a[15:8], a[6:0], alu_cy}; end
      5'd9:  begin co = a[0];
               alu_r = alu_size ? {alu_cy, a[15:1]} : {a[15:8], alu_cy, a[7:1]}; end
      5'd10, 5'd13: begin co = alu_size ? a[15] : a[7];
               alu_r = alu_size ? {a[14:0], 1'b0} : {a[15:8], a[6:0], 1'b0}; end
      5'd11: begin co = a[0];
               alu_r = alu_size ? {1'b0, a[15:1]} : {a[15:8], 1'b0, a[7:1]}; end
      5'd12: begin co = a[0];
               alu_r = alu_size ? {a[15], a[15:1]} : {a[15:8], a[7], a[7:1]}; end
      default: begin co = 1'b0; alu_r = a; end
    endcase
    r_top     = alu_size ? alu_r[15] : alu_r[7];
    alu_flags = {(alu_size ? (alu_r == 16'd0) : (alu_r[7:0] == 8'd0)),
                 r_top, ~^alu_r[7:0], r_top ^ co, co, 1'b1};
  end

  task automatic issue(input logic [4:0] o, input logic s, input logic [15:0] a,
                       input logic [7:0] c, input logic [5:0] f);
    @(negedge clk);
    op = o; size = s; operand = a; count = c; flags_in = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc,
                           output logic [15:0] res, output logic [5:0] fl);
    cyc = 0; res = 16'd0; fl = 6'd0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = c; res = result; fl = flags;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, result, flags} !== 24'd0) begin
      bad++;
      $display("FAIL reset_status: got busy=%b done=%b result=%h flags=%h, want all 0",
               busy, done, result, flags);
    end
    total++;
    if ({alu_op, alu_size, alu_a, alu_b, alu_cy} !== 39'd0) begin
      bad++;
      $display("FAIL reset_alu: got op=%h size=%b a=%h b=%h cy=%b, want all 0",
               alu_op, alu_size, alu_a, alu_b, alu_cy);
    end
    reset = 1'b0;
  endtask

  task automatic test_shl_byte;
    issue(5'd10, 1'b0, 16'h0081, 8'd1, 6'h00);
    @(negedge clk);
    total++;
    if ({busy, done, alu_b, alu_op} !== {1'b1, 1'b0, 16'd1, 5'd10}) begin
      bad++;
      $display("FAIL shl_cycle1: got busy=%b done=%b b=%h op=%0d, want 1 0 0001 10",
               busy, done, alu_b, alu_op);
    end
    @(negedge clk);
    total++;
    if ({done, alu_b} !== {1'b1, 16'd0}) begin
      bad++;
      $display("FAIL shl_cycle2: got done=%b b=%h, want 1 0000", done, alu_b);
    end
    total++;
    if ({result[7:0], flags} !== {8'h02, 6'h06}) begin
      bad++;
      $display("FAIL shl_value: got r=%h flags=%h, want 02 06", result[7:0], flags);
    end
  endtask

  task automatic test_ror_word;
    logic [15:0] exp_a [4];
    exp_a = '{16'h0001, 16'h8000, 16'h4000, 16'h2000};
    issue(5'd7, 1'b1, 16'h0001, 8'd4, 6'h00);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({alu_a, alu_b, done} !== {exp_a[c], 16'd1, 1'b0}) begin
        bad++;
        $display("FAIL ror_step%0d: got a=%h b=%h done=%b, want a=%h b=0001 done=0",
                 c + 1, alu_a, alu_b, done, exp_a[c]);
      end
    end
    @(negedge clk);
    total++;
    if ({done, result} !== {1'b1, 16'h1000}) begin
      bad++;
      $display("FAIL ror_done: got done=%b result=%h, want 1 1000", done, result);
    end
  endtask

  task automatic test_zero_count;
    issue(5'd11, 1'b1, 16'h1234, 8'd0, 6'h2A);
    @(negedge clk);
    total++;
    if ({done, result, flags, alu_op} !== {1'b1, 16'h1234, 6'h2A, 5'd0}) begin
      bad++;
      $display("FAIL zero_count: got done=%b result=%h flags=%h op=%0d, want 1 1234 2a 0",
               done, result, flags, alu_op);
    end
    @(negedge clk);
    total++;
    if ({done, busy, alu_op} !== 7'd0) begin
      bad++;
      $display("FAIL zero_after: got done=%b busy=%b op=%0d, want 0 0 0", done, busy, alu_op);
    end
  endtask

  task automatic test_rolc_byte;
    issue(5'd8, 1'b0, 16'h0080, 8'd1, 6'h22);
    @(negedge clk);
    total++;
    if (alu_cy !== 1'b1) begin
      bad++;
      $display("FAIL rolc_cy_in: got %b, want 1", alu_cy);
    end
    @(negedge clk);
    total++;
    if ({done, result[7:0], flags} !== {1'b1, 8'h01, 6'h26}) begin
      bad++;
      $display("FAIL rolc_done: got done=%b r=%h flags=%h, want 1 01 26",
               done, result[7:0], flags);
    end
  endtask

  task automatic test_unsupported;
    issue(5'd14, 1'b1, 16'hBEEF, 8'd5, 6'h15);
    @(negedge clk);
    total++;
    if ({done, result, flags, alu_b} !== {1'b1, 16'hBEEF, 6'h15, 16'd0}) begin
      bad++;
      $display("FAIL unsupported: got done=%b result=%h flags=%h b=%h, want 1 beef 15 0000",
               done, result, flags, alu_b);
    end
  endtask

  task automatic test_count_mask;
    int          cyc;
    logic [15:0] res;
    logic [5:0]  fl;
    issue(5'd11, 1'b1, 16'hFFFF, 8'h21, 6'h00);
    wait_done(40, cyc, res, fl);
`ifdef ALU_SEQ_COUNT_MASK_EN
    total++;
    if (cyc !== 2 || res !== 16'h7FFF) begin
      bad++;
      $display("FAIL count_mask: got cycle=%0d result=%h, want 2 7fff", cyc, res);
    end
`else
    total++;
    if (cyc !== 34 || res !== 16'h0000 || fl[5] !== 1'b1) begin
      bad++;
      $display("FAIL count_full: got cycle=%0d result=%h Z=%b, want 34 0000 1", cyc, res, fl[5]);
    end
`endif
  endtask

  task automatic test_start_ignored;
    int          n_done = 0;
    int          done_cyc = 0;
    logic [15:0] res = 16'd0;
    logic [4:0]  op_c4 = 5'd0;
    issue(5'd6, 1'b1, 16'h1234, 8'd8, 6'h00);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++; done_cyc = c; res = result;
      end
      if (c == 4) op_c4 = alu_op;
      if (c == 3 || c == 9) begin
        op = 5'd10; operand = 16'hFFFF; count = 8'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    total++;
    if (op_c4 !== 5'd6) begin
      bad++;
      $display("FAIL ignore_op: got alu_op=%0d in cycle 4, want 6", op_c4);
    end
    total++;
    if (n_done !== 1 || done_cyc !== 9 || res !== 16'h3412) begin
      bad++;
      $display("FAIL ignore_start: got dones=%0d cycle=%0d result=%h, want 1 9 3412",
               n_done, done_cyc, res);
    end
    total++;
    if ({busy, result} !== {1'b0, 16'h3412}) begin
      bad++;
      $display("FAIL result_hold: got busy=%b result=%h, want 0 3412", busy, result);
    end
  endtask

  task automatic test_back_to_back;
    int          first = 0;
    int          second = 0;
    int          n_done = 0;
    logic [15:0] res = 16'd0;
    @(negedge clk);
    op = 5'd10; size = 1'b1; operand = 16'h0001; count = 8'd2; flags_in = 6'h00;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) first = c; else second = c;
        res = result;
      end
      if (c == 5) start = 1'b0;
    end
    total++;
    if (n_done !== 2 || first !== 3 || second !== 7 || res !== 16'h0004) begin
      bad++;
      $display("FAIL back_to_back: got dones=%0d at %0d,%0d result=%h, want 2 at 3,7 0004",
               n_done, first, second, res);
    end
  endtask

  task automatic test_reset_abort;
    int          n_done = 0;
    int          cyc;
    logic [15:0] res;
    logic [5:0]  fl;
    issue(5'd11, 1'b1, 16'h8000, 8'd15, 6'h00);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (c == 3) reset = 1'b1;
      if (c == 4) begin
        total++;
        if ({busy, done, result, alu_a} !== 34'd0) begin
          bad++;
          $display("FAIL abort_state: got busy=%b done=%b result=%h a=%h, want 0 0 0000 0000",
                   busy, done, result, alu_a);
        end
        reset = 1'b0;
      end
    end
    total++;
    if (n_done !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", n_done);
    end
    issue(5'd11, 1'b1, 16'h8000, 8'd15, 6'h00);
    wait_done(30, cyc, res, fl);
    total++;
    if (cyc !== 16 || res !== 16'h0001) begin
      bad++;
      $display("FAIL abort_retry: got cycle=%0d result=%h, want 16 0001", cyc, res);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 5'd0; size = 1'b0;
    operand = 16'd0; count = 8'd0; flags_in = 6'd0;
    test_reset();
    test_shl_byte();
    test_ror_word();
    test_zero_count();
    test_rolc_byte();
    test_unsupported();
    test_count_mask();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_shift_seq.md
# alu_shift_seq

Multi-cycle sequencer for the shift/rotate group of `alu`. It accepts a shift or rotate command with an arbitrary count, then drives `alu` with a single-bit step (B = 1) once per cycle until the count is exhausted. It merges the per-step flags and returns the final result and flag word. It sits between instruction execute control and the `alu` instance, and owns the ALU inputs whenever `busy` is high.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  — single system clock; all state changes on its rising edge
- `reset`  in  1  — synchronous, active-high
- `start`  in  1  — command strobe; sampled only in IDLE
- `op`  in  5  — AluOp code; valid range ALUOP_ROL(6) … ALUOP_SHLA(13)
- `size`  in  1  — 0 = byte, 1 = word; forwarded to the ALU unchanged
- `operand`  in  16  — value to shift
- `count`  in  8  — shift count
- `flags_in`  in  6  — current flag word, AluFlags bit order (AC=0, CY=1, V=2, P=3, S=4, Z=5)
- `alu_op`  out  5  — to ALU `alu_op`
- `alu_size`  out  1  — to ALU `size`
- `alu_a`  out  16  — to ALU `A`
- `alu_b`  out  16  — to ALU `B`
- `alu_cy`  out  1  — carry-in for ROLC/RORC steps
- `alu_r`  in  16  — ALU `R`
- `alu_flags`  in  6  — ALU `flags`
- `busy`  out  1  — command in progress
- `done`  out  1  — one-cycle completion pulse
- `result`  out  16  — final value, valid while `done` = 1
- `flags`  out  6  — final flag word, valid while `done` = 1

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:**
  - On `start` = 1, latch `op`, `size`, `acc` ← `operand`, `flg` ← `flags_in`, and `cnt` ← effective count.
  - If effective count = 0 or `op` is outside 6..13, go to DONE. Otherwise go to RUN.
- **RUN:** each cycle,
  - drive `alu_op` = latched op, `alu_size` = latched size, `alu_a` = `acc`, `alu_b` = 16'd1, `alu_cy` = `flg[CY]`;
  - on the clock edge, `acc` ← `alu_r`, merge `alu_flags` into `flg` through the op mask, and `cnt` ← `cnt` − 1;
  - when `cnt` = 1 at the edge, go to DONE.
- **Op masks:**
  - ROL/ROR/ROLC/RORC update CY and V only.
  - SHL/SHR/SHRA/SHLA update CY, V, P, S and Z.
  - AC is never modified.
- **DONE:** `done` = 1, `result` = `acc`, `flags` = `flg`. Next state is IDLE.
- **Outside RUN:** `alu_op`, `alu_a`, `alu_b` and `alu_cy` are driven to 0.
- `start` while `busy` = 1 is ignored and is not queued.
- The upper byte of `acc` in byte mode is whatever the ALU returns. The consumer writes back only the low byte.
- An unsupported op completes as a zero-count command: `result` = `operand`, `flags` = `flags_in`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `result` = 0, `flags` = 0, and all `alu_*` outputs = 0.
- Latency (command accepted at edge 0):
  - effective count N ≥ 1: RUN occupies cycles 1..N and `done` is high in cycle N+1;
  - N = 0: `done` is high in cycle 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive, and low in IDLE.
- Back-to-back: the earliest next `start` accepted is the cycle after `done`. Throughput is one command per N+2 cycles.
- `result` and `flags` hold their values after `done` until the next command's DONE.
- The ALU is purely combinational. `alu_r` and `alu_flags` are sampled in the same cycle the `alu_*` outputs are driven.
- `reset` asserted mid-RUN aborts the command:
  - next cycle is IDLE with all outputs at reset values;
  - no `done` is issued for the aborted command.

## Configuration
- **`ALU_SEQ_COUNT_MASK_EN` defined:** effective count = `count[4:0]`, so the maximum is 31 steps and `done` arrives no later than cycle 32.
- **`ALU_SEQ_COUNT_MASK_EN` undefined:** effective count = full `count[7:0]`, so the maximum is 255 steps and `done` arrives no later than cycle 256.

## Test plan
1. SHL, byte, `operand` = 0x0081, `count` = 1, `flags_in` = 0 → `done` in cycle 2, `result[7:0]` = 0x02, `flags[CY]` = 1, `flags[S]` = 0; `alu_b` = 1 during cycle 1 only.
2. ROR, word, `operand` = 0x0001, `count` = 4 → exactly 4 RUN cycles with `alu_a` sequence 0x0001, 0x8000, 0x4000, 0x2000; `done` in cycle 5, `result` = 0x1000.
3. Zero count: SHR, `operand` = 0x1234, `flags_in` = 0x2A, `count` = 0 → `done` in cycle 1, `result` = 0x1234, `flags` = 0x2A; `alu_op` stays 0 throughout.
4. `count` = 0x21, SHR, word, `operand` = 0xFFFF:
   - with the macro defined: 1 step, `done` in cycle 2, `result` = 0x7FFF;
   - without the macro: 33 steps, `done` in cycle 34, `result` = 0x0000, `flags[Z]` = 1.
5. ROL, word, `count` = 8, `operand` = 0x1234; second `start` (SHL, 0xFFFF, count 1) pulsed in cycles 3 and 9 → both pulses ignored, single `done` in cycle 9, `result` = 0x3412.
6. `reset` asserted in cycle 3 of a word SHR, 0x8000, count 15 → cycle 4 has `busy` = 0, `result` = 0, `alu_a` = 0, and no `done` ever follows; a new count-15 command then yields `result` = 0x0001 with `done` 16 cycles after acceptance.
